// File: rtl/decoder_scan_sequencer_if.sv
// rtl/decoder_scan_sequencer_if.sv - control and decoder-drive signals of the scan sequencer
interface decoder_scan_sequencer_if #(
  parameter int SEL_W = 1
);
  logic             START;
  logic             STOP;
  logic             MODE;
  logic             EN;
  logic [SEL_W-1:0] I;
  logic             BUSY;
  logic             WRAP;
  logic             DONE;

  modport master (
    output START, STOP, MODE,
    input  EN, I, BUSY, WRAP, DONE
  );

  modport slave (
    input  START, STOP, MODE,
    output EN, I, BUSY, WRAP, DONE
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - steps a decoder select code with dwell and blanking gaps
module decoder_scan_sequencer #(
  parameter int SEL_W = 1,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  decoder_scan_sequencer_if.slave   bus
);
  localparam int MAXT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [SEL_W-1:0] I_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DWELL
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             mode_q;
  logic             en_q;
  logic [SEL_W-1:0] i_q;
  logic             busy_q;
  logic             wrap_q;
  logic             done_q;

  assign bus.EN   = en_q;
  assign bus.I    = i_q;
  assign bus.BUSY = busy_q;
  assign bus.WRAP = wrap_q;
  assign bus.DONE = done_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      en_q   <= 1'b0;
      i_q    <= '0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START && !bus.STOP) begin
            mode_q <= bus.MODE;
            i_q    <= '0;
            busy_q <= 1'b1;
            cnt    <= '0;
            if (BLANK == 0) begin
              state <= ST_DWELL;
              en_q  <= 1'b1;
            end else begin
              state <= ST_BLANK;
              en_q  <= 1'b0;
            end
          end
        end
        ST_BLANK: begin
          if (bus.STOP) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            en_q   <= 1'b0;
            i_q    <= '0;
            busy_q <= 1'b0;
          end else if (int'(cnt) == BLANK - 1) begin
            state <= ST_DWELL;
            cnt   <= '0;
            en_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DWELL: begin
          // STOP wins over a dwell that happens to expire in the same cycle
          if (bus.STOP) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            en_q   <= 1'b0;
            i_q    <= '0;
            busy_q <= 1'b0;
          end else if (int'(cnt) == DWELL - 1) begin
            cnt <= '0;
            if (i_q != I_MAX || !mode_q) begin
              if (i_q != I_MAX) begin
                i_q <= i_q + 1'b1;
              end else begin
                i_q    <= '0;
                wrap_q <= 1'b1;
              end
              // Without blanking the next code goes out with EN still high
              if (BLANK == 0) begin
                state <= ST_DWELL;
                en_q  <= 1'b1;
              end else begin
                state <= ST_BLANK;
                en_q  <= 1'b0;
              end
            end else begin
              state  <= ST_IDLE;
              i_q    <= '0;
              en_q   <= 1'b0;
              busy_q <= 1'b0;
              wrap_q <= 1'b1;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          en_q   <= 1'b0;
          i_q    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb/tb_decoder_scan_sequencer.sv - directed bench for decoder_scan_sequencer
module tb_decoder_scan_sequencer;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  decoder_scan_sequencer_if #(.SEL_W(1)) ifa ();
  decoder_scan_sequencer_if #(.SEL_W(2)) ifb ();

  decoder_scan_sequencer #(.SEL_W(1), .DWELL(4), .BLANK(1)) dut_a (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (ifa)
  );

  decoder_scan_sequencer #(.SEL_W(2), .DWELL(1), .BLANK(0)) dut_b (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] vec_a();
    return {3'b000, ifa.EN, ifa.I, ifa.BUSY, ifa.WRAP, ifa.DONE};
  endfunction

  function automatic logic [7:0] vec_b();
    return {2'b00, ifb.EN, ifb.I, ifb.BUSY, ifb.WRAP, ifb.DONE};
  endfunction

  // Default-parameter schedule: period of 10 cycles, {EN,I,BUSY,WRAP,DONE}
  function automatic logic [7:0] exp_a(input int c, input bit single);
    int   p;
    logic en, i, busy, wrap, done;
    p    = ((c - 1) % 10) + 1;
    en   = ((p >= 2) && (p <= 5)) || (p >= 7);
    i    = (p >= 6);
    busy = 1'b1;
    wrap = (c > 1) && (p == 1);
    done = 1'b0;
    if (single && c == 11) begin
      busy = 1'b0;
      done = 1'b1;
    end
    return {3'b000, en, i, busy, wrap, done};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       prev_en;
    logic       prev_i;
    logic [1:0] ib;
    checks   = 0;
    failures = 0;
    rstn      = 1'b0;
    ifa.START = 1'b1;
    ifa.STOP  = 1'b0;
    ifa.MODE  = 1'b0;
    ifb.START = 1'b1;
    ifb.STOP  = 1'b0;
    ifb.MODE  = 1'b0;

    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("reset_a_%0d", k), vec_a(), 8'h00);
      check($sformatf("reset_b_%0d", k), vec_b(), 8'h00);
    end
    rstn      = 1'b1;
    ifa.START = 1'b0;
    ifb.START = 1'b0;
    step();
    check("idle_after_reset", vec_a(), 8'h00);

    // single pass
    ifa.MODE  = 1'b1;
    ifa.START = 1'b1;
    step();
    ifa.START = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("single_c%0d", c), vec_a(), exp_a(c, 1'b1));
      if (c != 11) step();
    end

    // continuous, MODE flipped mid-scan must not matter
    ifa.MODE  = 1'b0;
    ifa.START = 1'b1;
    step();
    ifa.START = 1'b0;
    prev_en = 1'b0;
    prev_i  = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      check($sformatf("cont_c%0d", c), vec_a(), exp_a(c, 1'b0));
      if (prev_en && ifa.EN) check($sformatf("cont_i_stable_c%0d", c), {7'd0, ifa.I}, {7'd0, prev_i});
      prev_en = ifa.EN;
      prev_i  = ifa.I;
      if (c == 15) ifa.MODE = 1'b1;
      if (c != 31) step();
    end
    ifa.STOP = 1'b1;
    step();
    ifa.STOP = 1'b0;
    check("cont_stop", vec_a(), 8'h00);

    // abort at cycle 4, restart at cycle 5 with START held during BUSY
    ifa.MODE  = 1'b1;
    ifa.START = 1'b1;
    step();
    ifa.START = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("abort_c%0d", c), vec_a(), exp_a(c, 1'b1));
      if (c != 4) step();
    end
    ifa.STOP = 1'b1;
    step();
    ifa.STOP = 1'b0;
    check("abort_c5", vec_a(), 8'h00);
    ifa.START = 1'b1;
    step();
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("restart_c%0d", c), vec_a(), exp_a(c, 1'b1));
      if (c == 10) ifa.START = 1'b0;
      if (c != 11) step();
    end
    // START accepted on the DONE cycle
    ifa.START = 1'b1;
    step();
    ifa.START = 1'b0;
    check("done_restart_c1", vec_a(), exp_a(1, 1'b1));
    step();
    check("done_restart_c2", vec_a(), exp_a(2, 1'b1));
    ifa.STOP = 1'b1;
    step();
    ifa.STOP = 1'b0;
    check("dwell_stop", vec_a(), 8'h00);

    // START and STOP together in IDLE
    ifa.START = 1'b1;
    ifa.STOP  = 1'b1;
    step();
    check("start_stop_0", vec_a(), 8'h00);
    step();
    check("start_stop_1", vec_a(), 8'h00);
    ifa.START = 1'b0;
    ifa.STOP  = 1'b0;

    // reset mid-scan
    ifa.MODE  = 1'b0;
    ifa.START = 1'b1;
    step();
    ifa.START = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("rst_scan_c%0d", c), vec_a(), exp_a(c, 1'b0));
      if (c != 7) step();
    end
    rstn = 1'b0;
    step();
    check("rst_scan_c8", vec_a(), 8'h00);
    rstn = 1'b1;
    step();
    check("rst_scan_c9", vec_a(), 8'h00);

    // BLANK=0, DWELL=1, SEL_W=2 single pass
    ifb.MODE  = 1'b1;
    ifb.START = 1'b1;
    step();
    ifb.START = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      ib = 2'(c - 1);
      if (c <= 4) check($sformatf("edge_c%0d", c), vec_b(), {2'b00, 1'b1, ib, 1'b1, 1'b0, 1'b0});
      else        check("edge_c5", vec_b(), {2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1});
      if (c != 5) step();
    end
    step();
    check("edge_idle", vec_b(), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
